apu_sample_scheduler: RTL and testbench

//  Rate-converts the APU mixer output (one sample per APU cycle) down to the audio-out sample rate.
//  A fractional phase accumulator schedules output sample events; each event captures the mixer value into a small FIFO.
//  The FIFO drains over a valid/ready handshake to the audio serializer (I2S/HDMI audio).

---
 rtl/apu_sample_scheduler.sv | 148 ++++++++++++++
 tb/tb_apu_sample_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_sample_scheduler.sv
// apu_sample_scheduler
// Rate-converts the APU mixer stream (one sample per APU cycle) down to the
// audio-out rate. A fractional phase accumulator generates sample events.
// Each event captures the mixer value into a small FIFO. The FIFO drains to
// the audio serializer over a valid/ready handshake.
// Optional feature macro: APU_SAMPLE_LPF_EN adds a one-pole IIR anti-alias
// filter ahead of the capture point. When the macro is undefined, raw mix_in
// is captured.
module apu_sample_scheduler #(
    parameter int AUDIO_DEPTH = 16,
    parameter int PHASE_W     = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int LPF_SHIFT   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          mix_valid,
    input  logic [AUDIO_DEPTH-1:0]        mix_in,
    input  logic [PHASE_W-1:0]            phase_inc,
    input  logic                          ovf_clr,
    input  logic                          sample_ready,
    output logic                          sample_valid,
    output logic [AUDIO_DEPTH-1:0]        sample_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    // The FIFO depth must be a power of two so that the pointers wrap for free.
    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || LPF_SHIFT < 1) begin : g_param_check
            $error("apu_sample_scheduler: FIFO_DEPTH must be a power of 2 >= 2, LPF_SHIFT >= 1");
        end
    endgenerate

    logic [PHASE_W-1:0]     phase;
    logic [PHASE_W:0]       phase_sum;
    logic                   step;
    logic                   carry;
    logic [AUDIO_DEPTH-1:0] cap_value;

    logic                   evt_q;
    logic [AUDIO_DEPTH-1:0] val_q;

    logic [AUDIO_DEPTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level;
    logic                   full;
    logic                   pop;
    logic                   push;
    logic                   drop;

    assign step      = mix_valid && enable;
    assign phase_sum = {1'b0, phase} + {1'b0, phase_inc};
    assign carry     = step && phase_sum[PHASE_W];

`ifdef APU_SAMPLE_LPF_EN
    localparam int ACC_W = AUDIO_DEPTH + LPF_SHIFT;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;

    // Filter update. The accumulator settles at 2^LPF_SHIFT * input and never
    // exceeds that bound, so modular arithmetic in ACC_W bits is exact.
    always_comb begin
        acc_next = acc + ACC_W'(mix_in) - (acc >> LPF_SHIFT);
    end

    // Filter state tracks every strobe, including those that arrive while scheduling is disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (mix_valid) begin
            acc <= acc_next;
        end
    end

    assign cap_value = acc_next[ACC_W-1:LPF_SHIFT];
`else
    assign cap_value = mix_in;
`endif

    // Phase accumulator and event/value pipeline register. A pending event is lost on reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase <= '0;
            evt_q <= 1'b0;
            val_q <= '0;
        end else begin
            if (step) begin
                phase <= phase_sum[PHASE_W-1:0];
            end
            evt_q <= carry;
            if (carry) begin
                val_q <= cap_value;
            end
        end
    end

    assign full = (level == LVL_W'(FIFO_DEPTH));
    assign pop  = sample_valid && sample_ready;
    // If the FIFO is full, a write is accepted only when a pop frees a slot in the same cycle.
    assign push = evt_q && (!full || pop);
    assign drop = evt_q && full && !pop;

    // FIFO storage. The contents need no reset because the level gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= val_q;
        end
    end

    // FIFO pointers, occupancy, and sticky overflow. When set and clear coincide, the set wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign sample_valid = (level != '0);
    assign sample_out   = sample_valid ? mem[rd_ptr] : '0;
    assign fifo_level   = level;

endmodule

// File: tb/tb_apu_sample_scheduler.sv
// Directed testbench for apu_sample_scheduler. The LPF scenario checks depend
// on whether APU_SAMPLE_LPF_EN is defined.
module tb_apu_sample_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        mix_valid;
    logic [15:0] mix_in;
    logic [23:0] phase_inc;
    logic        ovf_clr;
    logic        sample_ready;
    logic        sample_valid;
    logic [15:0] sample_out;
    logic [2:0]  fifo_level;
    logic        overflow;

    int errors;
    int checks;

    apu_sample_scheduler #(
        .AUDIO_DEPTH (16),
        .PHASE_W     (24),
        .FIFO_DEPTH  (4),
        .LPF_SHIFT   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .mix_valid    (mix_valid),
        .mix_in       (mix_in),
        .phase_inc    (phase_inc),
        .ovf_clr      (ovf_clr),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_out   (sample_out),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] v);
        mix_valid = 1'b1;
        mix_in    = v;
        @(posedge clk);
        #1;
        mix_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        mix_valid    = 1'b0;
        ovf_clr      = 1'b0;
        enable       = 1'b1;
        sample_ready = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", sample_valid); end
        checks++; if (sample_out !== 16'h0) begin errors++; $display("FAIL reset_out got=%h exp=0000", sample_out); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%0b exp=0", overflow); end
        rst = 1'b1;
        phase_inc = 24'h800000;
        for (int j = 0; j < 6; j++) strobe(16'h0010 + 16'(j));
        tick();
        tick();
        checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL prereset_level got=%0d exp=3", fifo_level); end
        checks++; if (sample_out !== 16'h0011) begin errors++; $display("FAIL prereset_head got=%h exp=0011", sample_out); end
        rst = 1'b0;
        tick();
        tick();
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got=%0b exp=0", sample_valid); end
        checks++; if (sample_out !== 16'h0) begin errors++; $display("FAIL midreset_out got=%h exp=0000", sample_out); end
        checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL midreset_level got=%0d exp=0", fifo_level); end
        rst = 1'b1;
        strobe(16'h0020);
        strobe(16'h0021);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL no_fallthrough got=%0b exp=0", sample_valid); end
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'h0021) begin
            errors++; $display("FAIL post_reset_event valid=%0b out=%h exp=1/0021", sample_valid, sample_out);
        end
        checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL post_reset_level got=%0d exp=1", fifo_level); end
    endtask

    task automatic test_rate();
        logic exp_v;
        do_reset();
        phase_inc    = 24'h400000;
        sample_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            strobe(16'(j));
            exp_v = (j % 4 == 0) && (j > 0);
            checks++;
            if (sample_valid !== exp_v || (exp_v && sample_out !== 16'(j - 1))) begin
                errors++;
                $display("FAIL rate_step%0d valid=%0b out=%h exp_valid=%0b exp_out=%h", j, sample_valid, sample_out, exp_v, 16'(j - 1));
            end
        end
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'd15) begin
            errors++; $display("FAIL rate_last valid=%0b out=%h exp=1/000f", sample_valid, sample_out);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        phase_inc = 24'h800000;
        for (int j = 0; j < 20; j++) strobe(16'd100 + 16'(j));
        tick();
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level got=%0d exp=4", fifo_level); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got=%0b exp=1", overflow); end
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'd101) begin
            errors++; $display("FAIL bp_head valid=%0b out=%0d exp=1/101", sample_valid, sample_out);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf_clr got=%0b exp=0", overflow); end
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== 16'(101 + 2 * i)) begin
                errors++; $display("FAIL bp_drain%0d valid=%0b out=%0d exp=1/%0d", i, sample_valid, sample_out, 101 + 2 * i);
            end
            tick();
        end
        checks++; if (sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL bp_empty valid=%0b level=%0d exp=0/0", sample_valid, fifo_level);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        phase_inc = 24'h800000;
        for (int j = 0; j < 8; j++) strobe(16'd200 + 16'(j));
        tick();
        tick();
        strobe(16'd208);
        strobe(16'd209);
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_full got=%0d exp=4", fifo_level); end
        sample_ready = 1'b1;
        tick();
        checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fp_level got=%0d exp=4", fifo_level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fp_ovf got=%0b exp=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sample_valid !== 1'b1 || sample_out !== 16'(203 + 2 * i)) begin
                errors++; $display("FAIL fp_drain%0d valid=%0b out=%0d exp=1/%0d", i, sample_valid, sample_out, 203 + 2 * i);
            end
            tick();
        end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL fp_empty got=%0b exp=0", sample_valid); end
    endtask

    task automatic test_enable_zero();
        logic seen;
        do_reset();
        phase_inc    = 24'h400000;
        sample_ready = 1'b1;
        strobe(16'd40);
        strobe(16'd41);
        enable = 1'b0;
        seen   = 1'b0;
        for (int j = 0; j < 99; j++) begin
            strobe(16'd50);
            if (sample_valid) seen = 1'b1;
        end
        tick();
        tick();
        if (sample_valid) seen = 1'b1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL en_off_events got=%0b exp=0", seen); end
        enable = 1'b1;
        strobe(16'd60);
        strobe(16'd61);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL en_resume_early got=%0b exp=0", sample_valid); end
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'd61) begin
            errors++; $display("FAIL en_resume valid=%0b out=%0d exp=1/61", sample_valid, sample_out);
        end
        tick();
        phase_inc = 24'h0;
        seen = 1'b0;
        for (int j = 0; j < 20; j++) begin
            strobe(16'd65);
            if (sample_valid) seen = 1'b1;
        end
        tick();
        tick();
        if (sample_valid) seen = 1'b1;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zero_inc_events got=%0b exp=0", seen); end
        phase_inc = 24'h400000;
        for (int j = 0; j < 4; j++) strobe(16'd70 + 16'(j));
        tick();
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'd73) begin
            errors++; $display("FAIL zero_inc_resume valid=%0b out=%0d exp=1/73", sample_valid, sample_out);
        end
    endtask

    task automatic test_lpf();
`ifdef APU_SAMPLE_LPF_EN
        logic [15:0] prev;
        logic [15:0] first;
        logic        have_first;
        logic        mono_ok;
`endif
        do_reset();
        phase_inc    = 24'hFFFFFF;
        sample_ready = 1'b1;
        strobe(16'h0000);
        strobe(16'h4000);
`ifdef APU_SAMPLE_LPF_EN
        prev       = 16'h0;
        first      = 16'h0;
        have_first = 1'b0;
        mono_ok    = 1'b1;
        for (int j = 0; j < 400; j++) begin
            strobe(16'h4000);
            if (sample_valid) begin
                if (!have_first) begin
                    first      = sample_out;
                    have_first = 1'b1;
                end
                if (sample_out < prev) mono_ok = 1'b0;
                prev = sample_out;
            end
        end
        checks++; if (mono_ok !== 1'b1) begin errors++; $display("FAIL lpf_monotonic got=%0b exp=1", mono_ok); end
        checks++; if (prev !== 16'h4000) begin errors++; $display("FAIL lpf_final got=%h exp=4000", prev); end
        checks++; if (!(have_first && first < 16'h4000)) begin
            errors++; $display("FAIL lpf_first got=%h exp=below 4000", first);
        end
`else
        strobe(16'h4000);
        checks++; if (sample_valid !== 1'b1 || sample_out !== 16'h4000) begin
            errors++; $display("FAIL raw_step valid=%0b out=%h exp=1/4000", sample_valid, sample_out);
        end
`endif
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        enable       = 1'b1;
        mix_valid    = 1'b0;
        mix_in       = 16'h0;
        phase_inc    = 24'h0;
        ovf_clr      = 1'b0;
        sample_ready = 1'b0;
        test_reset();
        test_rate();
        test_backpressure();
        test_full_pop();
        test_enable_zero();
        test_lpf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
